// File: rtl/vga_fetch_pkg.sv
// Shared types and default sizing for the VGA line-fetch / draw-write arbiter.
package vga_fetch_pkg;

  localparam int unsigned LINE_WORDS_DEF = 640;
  localparam int unsigned ADDR_W_DEF     = 25;
  localparam int unsigned DATA_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic is_read_state(input fetch_state_t s);
    return (s == RD_ISSUE) || (s == RD_DRAIN);
  endfunction

endpackage

// File: rtl/vga_fetch_arbiter_fetch_counter.sv
// Enable/clear counter that saturates at TERMINAL; used for line issue and return counts.
module fetch_counter #(
  parameter int unsigned TERMINAL = 640,
  parameter int unsigned WIDTH    = $clog2(TERMINAL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_term;

  assign w_at_term = (r_count == WIDTH'(TERMINAL));

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_term) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Arbitrates one SDRAM port between display line prefetch (strict priority) and a single-word draw writer.
module vga_fetch_arbiter
  import vga_fetch_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              LINE_REQ,
  input  logic [ADDR_W-1:0] LINE_ADDR,
  output logic              LINE_BUSY,
  output logic              LINE_OVERRUN,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ACK,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_RD,
  output logic              MEM_WR,
  input  logic              MEM_WAIT,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_RDVALID
);

  localparam int unsigned      CNT_W    = $clog2(LINE_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_line_pending;
  logic [ADDR_W-1:0] r_base;
  logic              r_overrun;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wr_ack;
  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;

  logic [CNT_W-1:0]  w_issue_cnt;
  logic [CNT_W-1:0]  w_return_cnt;
  logic              w_in_rd;
  logic              w_line_busy;
  logic              w_line_take;
  logic              w_return_en;
  logic              w_wr_req;
  logic              w_cnt_clr;
  logic              w_issue_en;
  logic              w_pending_clr;
  logic              w_ack_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  assign w_in_rd     = is_read_state(r_state);
  assign w_line_busy = r_line_pending | w_in_rd;
  assign w_line_take = LINE_REQ & ~w_line_busy;
  assign w_return_en = MEM_RDVALID & w_in_rd;
  // The writer still holds WR_REQ during its ack cycle; that request is already served.
  assign w_wr_req    = WR_REQ & ~r_wr_ack;

  fetch_counter #(
    .TERMINAL (LINE_WORDS),
    .WIDTH    (CNT_W)
  ) u_issue_cnt (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_clr   (w_cnt_clr),
    .i_en    (w_issue_en),
    .o_count (w_issue_cnt)
  );

  fetch_counter #(
    .TERMINAL (LINE_WORDS),
    .WIDTH    (CNT_W)
  ) u_return_cnt (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_clr   (w_cnt_clr),
    .i_en    (w_return_en),
    .o_count (w_return_cnt)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave a value held (no inferred latch).
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_mem_addr;
    w_wdata_nxt   = r_mem_wdata;
    w_ack_nxt     = 1'b0;
    w_cnt_clr     = 1'b0;
    w_issue_en    = 1'b0;
    w_pending_clr = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (r_line_pending) begin
          w_state_nxt   = RD_ISSUE;
          w_pending_clr = 1'b1;
          w_cnt_clr     = 1'b1;
          w_addr_nxt    = r_base;
        end else if (w_wr_req) begin
          w_state_nxt = WR;
          w_addr_nxt  = WR_ADDR;
          w_wdata_nxt = WR_DATA;
        end
      end
      WR: begin
        if (!MEM_WAIT) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = 1'b1;
        end
      end
      RD_ISSUE: begin
        if (!MEM_WAIT) begin
          w_issue_en = 1'b1;
          if (w_issue_cnt == LAST_IDX) begin
            w_state_nxt = RD_DRAIN;
          end else begin
            w_addr_nxt = r_base + ADDR_W'(w_issue_cnt + CNT_W'(1));
          end
        end
      end
      RD_DRAIN: begin
        if (w_return_cnt == FULL_CNT) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_line_pending <= 1'b0;
      r_base         <= '0;
      r_overrun      <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_wr_ack       <= 1'b0;
      r_pix_valid    <= 1'b0;
      r_pix_data     <= '0;
    end else begin
      r_mem_rd    <= (w_state_nxt == RD_ISSUE);
      r_mem_wr    <= (w_state_nxt == WR);
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_wr_ack    <= w_ack_nxt;
      r_pix_valid <= w_return_en;
      if (w_return_en) begin
        r_pix_data <= MEM_RDATA;
      end
      if (w_line_take) begin
        r_line_pending <= 1'b1;
        r_base         <= LINE_ADDR;
      end else if (w_pending_clr) begin
        r_line_pending <= 1'b0;
      end
      if (LINE_REQ && w_line_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign LINE_BUSY    = w_line_busy;
  assign LINE_OVERRUN = r_overrun;
  assign PIX_DATA     = r_pix_data;
  assign PIX_VALID    = r_pix_valid;
  assign WR_ACK       = r_wr_ack;
  assign MEM_ADDR     = r_mem_addr;
  assign MEM_WDATA    = r_mem_wdata;
  assign MEM_RD       = r_mem_rd;
  assign MEM_WR       = r_mem_wr;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed-plus-random bench: an SDRAM responder with random stall/latency and a line/write expectation model.
module tb_vga_fetch_arbiter;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;

  logic          CLK;
  logic          RESET_N;
  logic          LINE_REQ;
  logic [AW-1:0] LINE_ADDR;
  logic          LINE_BUSY;
  logic          LINE_OVERRUN;
  logic [DW-1:0] PIX_DATA;
  logic          PIX_VALID;
  logic          WR_REQ;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          WR_ACK;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_RD;
  logic          MEM_WR;
  logic          MEM_WAIT;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_RDVALID;

  vga_fetch_arbiter #(
    .LINE_WORDS (LW),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .LINE_REQ     (LINE_REQ),
    .LINE_ADDR    (LINE_ADDR),
    .LINE_BUSY    (LINE_BUSY),
    .LINE_OVERRUN (LINE_OVERRUN),
    .PIX_DATA     (PIX_DATA),
    .PIX_VALID    (PIX_VALID),
    .WR_REQ       (WR_REQ),
    .WR_ADDR      (WR_ADDR),
    .WR_DATA      (WR_DATA),
    .WR_ACK       (WR_ACK),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_RD       (MEM_RD),
    .MEM_WR       (MEM_WR),
    .MEM_WAIT     (MEM_WAIT),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_RDVALID  (MEM_RDVALID)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int wait_pct = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int wr_stall = 0;

  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] pix_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int rd_cycles, wr_cycles, wr_unstable, ack_cnt, ack_cyc, last_pix_cyc, overlap;

  logic [AW-1:0] ret_addr_q[$];
  int            ret_due_q[$];
  int            last_due = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E3779B1;
    return t[23:8] ^ 16'h5A5A;
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // SDRAM responder and output monitor.
  initial begin
    int  due;
    logic          prev_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    prev_wr = 1'b0; prev_addr = '0; prev_data = '0;
    MEM_WAIT = 1'b0; MEM_RDVALID = 1'b0; MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_RD) rd_cycles++;
      if (MEM_RD && !MEM_WAIT) begin
        rd_log.push_back(MEM_ADDR);
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_addr_q.push_back(MEM_ADDR);
        ret_due_q.push_back(due);
      end
      if (MEM_WR) begin
        wr_cycles++;
        if (prev_wr && (MEM_ADDR !== prev_addr || MEM_WDATA !== prev_data)) wr_unstable++;
        if (!MEM_WAIT) begin
          wr_addr_log.push_back(MEM_ADDR);
          wr_data_log.push_back(MEM_WDATA);
        end
      end
      prev_wr = MEM_WR; prev_addr = MEM_ADDR; prev_data = MEM_WDATA;
      if (MEM_RD && MEM_WR) overlap++;
      if (PIX_VALID) begin
        pix_log.push_back(PIX_DATA);
        last_pix_cyc = cyc;
      end
      if (WR_ACK) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
      @(posedge CLK);
      #1;
      cyc++;
      MEM_RDVALID = 1'b0;
      if (ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
        MEM_RDVALID = 1'b1;
        MEM_RDATA   = mem_word(ret_addr_q.pop_front());
        void'(ret_due_q.pop_front());
      end
      if (wr_stall > 0 && MEM_WR) begin
        MEM_WAIT = 1'b1;
        wr_stall--;
      end else begin
        MEM_WAIT = (wait_pct != 0) && (int'($urandom_range(99, 0)) < wait_pct);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); pix_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    rd_cycles = 0; wr_cycles = 0; wr_unstable = 0; ack_cnt = 0;
    ack_cyc = 0; last_pix_cyc = 0; overlap = 0;
  endtask

  task automatic pulse_line(input logic [AW-1:0] a);
    LINE_REQ  = 1'b1;
    LINE_ADDR = a;
    step(1);
    LINE_REQ  = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int   quiet;
    logic done;
    quiet = 0; done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      #1;
      if (!LINE_BUSY && !MEM_RD && !MEM_WR && !PIX_VALID && !WR_ACK && ret_due_q.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) done = 1'b1;
    end
    check({tag, " settle"}, 32'(done), 32'd1);
    step(1);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget);
    logic got;
    got = 1'b0;
    WR_REQ = 1'b1; WR_ADDR = a; WR_DATA = d;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge CLK);
      if (WR_ACK) got = 1'b1;
    end
    step(1);
    WR_REQ = 1'b0;
    check({tag, " ack seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    check({tag, " read count"}, rd_log.size(), LW);
    check({tag, " pixel count"}, pix_log.size(), LW);
    for (int i = 0; i < int'(LW); i++) begin
      a = base + AW'(i);
      check($sformatf("%s addr[%0d]", tag, i),
            (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hxxxxxxxx, 32'(a));
      check($sformatf("%s pix[%0d]", tag, i),
            (i < pix_log.size()) ? 32'(pix_log[i]) : 32'hxxxxxxxx, 32'(mem_word(a)));
    end
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check({tag, " write count"}, wr_addr_log.size(), 1);
    check({tag, " write addr"}, (wr_addr_log.size() > 0) ? 32'(wr_addr_log[0]) : 32'hxxxxxxxx, 32'(a));
    check({tag, " write data"}, (wr_data_log.size() > 0) ? 32'(wr_data_log[0]) : 32'hxxxxxxxx, 32'(d));
    check({tag, " ack pulses"}, ack_cnt, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctrl outs"}, 32'({MEM_RD, MEM_WR, WR_ACK, PIX_VALID, LINE_BUSY, LINE_OVERRUN}), 32'd0);
    check({tag, " mem_addr"}, 32'(MEM_ADDR), 32'd0);
    check({tag, " mem_wdata"}, 32'(MEM_WDATA), 32'd0);
    check({tag, " pix_data"}, 32'(PIX_DATA), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] base;
    logic [AW-1:0] other;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          got;

    RESET_N = 1'b0; LINE_REQ = 1'b0; LINE_ADDR = '0;
    WR_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    clear_logs();
    step(3);
    check_zero("reset");
    RESET_N = 1'b1;
    step(2);

    // Line fetch, no stall, fixed return latency 3.
    clear_logs();
    wait_pct = 0; lat_min = 3; lat_max = 3;
    pulse_line(25'h1000);
    check("t1 busy after req", 32'(LINE_BUSY), 32'd1);
    wait_quiet("t1", 200);
    check_burst("t1", 25'h1000);
    check("t1 rd cycles", rd_cycles, LW);
    check("t1 busy after", 32'(LINE_BUSY), 32'd0);

    // Single write with two stall cycles.
    clear_logs();
    wr_stall = 2;
    do_write("t2", 25'h20, 16'hBEEF, 50);
    wait_quiet("t2", 50);
    check_write("t2", 25'h20, 16'hBEEF);
    check("t2 wr cycles", wr_cycles, 3);
    check("t2 wr stable", wr_unstable, 0);
    check("t2 no reads", rd_cycles, 0);

    // Pending line and write in IDLE together: line goes first.
    clear_logs();
    wait_pct = 30; lat_min = 1; lat_max = 5;
    base  = AW'($urandom);
    waddr = AW'($urandom);
    wdata = DW'($urandom);
    pulse_line(base);
    do_write("t3", waddr, wdata, 400);
    wait_quiet("t3", 200);
    check_burst("t3", base);
    check_write("t3", waddr, wdata);
    check("t3 ack after last pixel", 32'(ack_cyc > last_pix_cyc), 32'd1);
    check("t3 no rd/wr overlap", overlap, 0);

    // Overrun: second request mid-fetch is dropped and flagged.
    clear_logs();
    base  = AW'($urandom);
    other = base ^ 25'h1000000;
    pulse_line(base);
    step(2);
    pulse_line(other);
    check("t4 overrun set", 32'(LINE_OVERRUN), 32'd1);
    wait_quiet("t4", 300);
    check_burst("t4", base);
    check("t4 overrun sticky", 32'(LINE_OVERRUN), 32'd1);

    // Address wrap at the top of the address space.
    clear_logs();
    pulse_line(25'h1FFFFFE);
    wait_quiet("t5", 300);
    check_burst("t5", 25'h1FFFFFE);
    check("t5 third addr wrapped", (rd_log.size() > 2) ? 32'(rd_log[2]) : 32'hxxxxxxxx, 32'd0);
    check("t5 overrun still set", 32'(LINE_OVERRUN), 32'd1);

    // Randomized line + write rounds.
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      wait_pct = int'($urandom_range(50, 0));
      lat_min  = 1;
      lat_max  = int'($urandom_range(6, 1));
      base     = AW'($urandom);
      pulse_line(base);
      wait_quiet($sformatf("r%0d line", k), 400);
      check_burst($sformatf("r%0d", k), base);
      clear_logs();
      waddr    = AW'($urandom);
      wdata    = DW'($urandom);
      wr_stall = int'($urandom_range(3, 0));
      do_write($sformatf("r%0d", k), waddr, wdata, 100);
      wait_quiet($sformatf("r%0d write", k), 100);
      check_write($sformatf("r%0d", k), waddr, wdata);
    end

    // Reset after two reads issued; late returns must be ignored.
    clear_logs();
    wait_pct = 0; lat_min = 8; lat_max = 8;
    pulse_line(25'h3000);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge CLK);
      #1;
      if (rd_log.size() == 2) got = 1'b1;
    end
    check("t6 two reads issued", 32'(got), 32'd1);
    step(1);
    RESET_N = 1'b0;
    #1;
    check_zero("t6 async reset");
    clear_logs();
    step(2);
    RESET_N = 1'b1;
    wait_quiet("t6 stray", 60);
    check("t6 stray pixels", pix_log.size(), 0);
    check("t6 no reads after reset", rd_log.size(), 0);
    clear_logs();
    lat_min = 2; lat_max = 2;
    base = AW'($urandom);
    pulse_line(base);
    wait_quiet("t6 refetch", 200);
    check_burst("t6 refetch", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fetch_arbiter.md
Name: vga_fetch_arbiter

Overview:
- Shares a single SDRAM controller port between two requesters:
  - display line prefetch, which fills the VGA line buffer feeding the colour path's pixel inputs;
  - a single-word draw writer.
- Display fetch has strict priority. A line fetch is a burst of LINE_WORDS pipelined reads, and every word returned is forwarded to the line buffer.
- Sits between the VGA control domain's line request and the SDRAM controller.

Parameters:
- LINE_WORDS, 640: read words per line fetch (>= 2).
- ADDR_W, 25: SDRAM word address width.
- DATA_W, 16: SDRAM data width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- LINE_REQ  in  1  one-cycle pulse: fetch the next line.
- LINE_ADDR  in  ADDR_W  base word address of the line; sampled with LINE_REQ.
- LINE_BUSY  out  1  a line is pending or being fetched.
- LINE_OVERRUN  out  1  sticky: LINE_REQ arrived while LINE_BUSY.
- PIX_DATA  out  DATA_W  returned pixel word.
- PIX_VALID  out  1  PIX_DATA valid this cycle.
- WR_REQ  in  1  writer request; held until WR_ACK.
- WR_ADDR  in  ADDR_W  write address; stable while WR_REQ.
- WR_DATA  in  DATA_W  write data; stable while WR_REQ.
- WR_ACK  out  1  one-cycle pulse when the write is accepted by SDRAM.
- MEM_ADDR  out  ADDR_W  command address.
- MEM_WDATA  out  DATA_W  write data.
- MEM_RD  out  1  read command.
- MEM_WR  out  1  write command.
- MEM_WAIT  in  1  controller stall; a command is accepted on an edge where it is asserted and MEM_WAIT=0.
- MEM_RDATA  in  DATA_W  read return data.
- MEM_RDVALID  in  1  read return strobe; returns are in order, latency arbitrary.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE; all counters 0; line_pending=0.
  - Outputs: MEM_RD=0, MEM_WR=0, WR_ACK=0, PIX_VALID=0, LINE_BUSY=0, LINE_OVERRUN=0, MEM_ADDR=0, MEM_WDATA=0, PIX_DATA=0.
  - Reset mid-fetch abandons the fetch. Late MEM_RDVALID after reset release are ignored, because return_cnt only counts in RD_ISSUE/RD_DRAIN.
- LINE_REQ handling:
  - LINE_REQ while !LINE_BUSY: latch LINE_ADDR into base, set line_pending.
  - LINE_REQ while LINE_BUSY: ignored, LINE_OVERRUN<=1 (cleared only by reset).
- LINE_BUSY = line_pending | (state in RD_ISSUE, RD_DRAIN).
- States:
  - IDLE:
    - line_pending → RD_ISSUE; clear line_pending; issue_cnt=0, return_cnt=0.
    - else WR_REQ → WR.
    - Both at once: the line wins.
    - LINE_REQ in the same cycle WR_REQ is seen in IDLE: line_pending is not yet set, so WR is entered. The line then waits at most one write.
  - WR:
    - MEM_WR=1, MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA.
    - On acceptance: WR_ACK=1 the next cycle (registered), MEM_WR drops, → IDLE.
    - Back-to-back writes: each one returns to IDLE, so a pending line is checked between writes.
  - RD_ISSUE:
    - MEM_RD=1, MEM_ADDR=base+issue_cnt, modulo 2^ADDR_W (address wraps, no error).
    - On acceptance, issue_cnt++.
    - When the accepted read has issue_cnt==LINE_WORDS-1 → RD_DRAIN, with MEM_RD=0 the next cycle.
  - RD_DRAIN:
    - MEM_RD=0.
    - When return_cnt reaches LINE_WORDS → IDLE. If the final return arrives on the transition edge, go to IDLE the next cycle.
- Returns:
  - In RD_ISSUE/RD_DRAIN, MEM_RDVALID increments return_cnt (also during issue).
  - PIX_DATA<=MEM_RDATA and PIX_VALID<=1, registered, 1-cycle latency.
  - MEM_RDVALID in IDLE/WR → PIX_VALID stays 0.
- Outputs are registered (MEM_* driven from state/counter registers). The command is held stable while MEM_WAIT=1.
- Widths: counters are $clog2(LINE_WORDS+1) bits; neither counter exceeds LINE_WORDS.

Decomposition:
- Package vga_fetch_pkg:
  - state enum {IDLE, WR, RD_ISSUE, RD_DRAIN};
  - default constants LINE_WORDS_DEF=640, ADDR_W_DEF=25, DATA_W_DEF=16.
- One sub-module: fetch_counter, a parameterised enable/clear/terminal-count counter, instantiated twice for issue_cnt and return_cnt.
- The FSM and muxing stay in the top.

Test Plan:
1. Line fetch, no stall: LINE_REQ with LINE_ADDR=0x1000, LINE_WORDS=4, MEM_WAIT=0, return latency 3 → MEM_RD for 4 cycles with addresses 0x1000..0x1003, exactly 4 PIX_VALID in order, then LINE_BUSY=0.
2. Single write: WR_REQ with addr 0x20, data 0xBEEF, MEM_WAIT high for 2 cycles → MEM_WR held 3 cycles with stable addr/data, exactly one WR_ACK, no MEM_RD.
3. Simultaneous requests in IDLE: LINE_REQ pending and WR_REQ both present → read burst first; WR_ACK only after the 4th return and return to IDLE.
4. Overrun: second LINE_REQ mid-fetch → LINE_OVERRUN=1 and stays 1; second address never issued.
5. Address wrap: ADDR_W=4, LINE_ADDR=0xE, LINE_WORDS=4 → addresses 0xE, 0xF, 0x0, 0x1.
6. Reset mid-fetch: RESET_N low after 2 of 4 reads issued → all outputs 0 immediately; stray MEM_RDVALID after release gives PIX_VALID=0; a new LINE_REQ fetches correctly.
